// File: rtl/paramult_vec_pipe.sv
// paramult_vec_pipe
//   N-lane signed fixed-point vector multiplier: out[i] = (a[i]*b[i]) >> FRAC,
//   with optional round-half-up and saturation per transfer. Fully pipelined
//   over LAT stages with a valid/ready handshake on both sides and a global
//   stall: when the output is valid and not accepted, every stage holds.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   in_v/in_rdy       input handshake; in_a/in_b packed lanes, lane i = [i*W +: W]
//   rnd_en/sat_en     arithmetic mode, captured with each input transfer
//   out_v/out_rdy     output handshake; out_res packed lanes, out_ovf per lane
//   ovf_cnt/ovf_clr   saturating count of output transfers with any overflow
//   busy              any stage (output included) holds a valid vector
module paramult_vec_pipe #(
  parameter int LANES = 16,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int LAT   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_v,
  output logic               in_rdy,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic               rnd_en,
  input  logic               sat_en,
  output logic               out_v,
  input  logic               out_rdy,
  output logic [LANES*W-1:0] out_res,
  output logic [LANES-1:0]   out_ovf,
  output logic [15:0]        ovf_cnt,
  input  logic               ovf_clr,
  output logic               busy
);

  localparam int PW     = 2 * W;
  localparam int MD     = (LAT > 2) ? LAT - 2 : 1;
  localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [PW:0] RND_K = (FRAC > 0) ? ((PW + 1)'(1) << RND_SH) : '0;

  logic                 adv;
  logic                 s1_v_q, s1_v_d, s1_rnd_q, s1_rnd_d, s1_sat_q, s1_sat_d;
  logic [LANES*W-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [MD-1:0]        md_v_q, md_v_d, md_rnd_q, md_rnd_d, md_sat_q, md_sat_d;
  logic [LANES*PW-1:0]  md_p_q [MD];
  logic [LANES*PW-1:0]  md_p_d [MD];
  logic                 out_v_q, out_v_d;
  logic [LANES*W-1:0]   out_res_q, out_res_d;
  logic [LANES-1:0]     out_ovf_q, out_ovf_d;
  logic [15:0]          ovf_cnt_q, ovf_cnt_d;
  logic [LANES*PW-1:0]  prod_c;
  logic                 fin_v, fin_rnd, fin_sat;
  logic [LANES*PW-1:0]  fin_p;

  // The whole pipe moves as one; bubbles are kept while stalled.
  assign adv     = ~out_v_q | out_rdy;
  assign in_rdy  = adv;
  assign out_v   = out_v_q;
  assign out_res = out_res_q;
  assign out_ovf = out_ovf_q;
  assign ovf_cnt = ovf_cnt_q;
  assign busy    = s1_v_q | out_v_q | ((LAT > 2) ? (|md_v_q) : 1'b0);

  // Returns {ovf, result}. The extra top bit keeps the rounding add exact.
  function automatic logic [W:0] round_sat(input logic [PW-1:0] p, input logic rnd,
                                           input logic sat);
    logic [PW:0]      pe;
    logic [PW:0]      s;
    logic [PW-W+1:0]  hi;
    logic             ovf;
    logic [W-1:0]     res;
    pe  = {p[PW-1], p} + (rnd ? RND_K : '0);
    s   = $unsigned($signed(pe) >>> FRAC);
    // In range only when every bit from the result sign upward agrees.
    hi  = s[PW:W-1];
    ovf = ~((&hi) | ~(|hi));
    res = s[W-1:0];
    if (sat && ovf) res = s[PW] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return {ovf, res};
  endfunction

  always_comb begin
    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_rnd_d = s1_rnd_q;
    s1_sat_d = s1_sat_q;
    if (adv) begin
      s1_v_d   = in_v;
      s1_a_d   = in_a;
      s1_b_d   = in_b;
      s1_rnd_d = rnd_en;
      s1_sat_d = sat_en;
    end
  end

  always_comb begin
    prod_c = '0;
    for (int l = 0; l < LANES; l++)
      prod_c[l*PW +: PW] = PW'($signed(s1_a_q[l*W +: W])) * PW'($signed(s1_b_q[l*W +: W]));
  end

  always_comb begin
    md_v_d   = md_v_q;
    md_rnd_d = md_rnd_q;
    md_sat_d = md_sat_q;
    md_p_d   = md_p_q;
    if (adv) begin
      md_v_d[0]   = s1_v_q;
      md_rnd_d[0] = s1_rnd_q;
      md_sat_d[0] = s1_sat_q;
      md_p_d[0]   = prod_c;
      for (int k = 1; k < MD; k++) begin
        md_v_d[k]   = md_v_q[k-1];
        md_rnd_d[k] = md_rnd_q[k-1];
        md_sat_d[k] = md_sat_q[k-1];
        md_p_d[k]   = md_p_q[k-1];
      end
    end
  end

  // With LAT=2 the product feeds the output stage directly.
  generate
    if (LAT > 2) begin : g_mid
      always_comb begin
        fin_v   = md_v_q[MD-1];
        fin_rnd = md_rnd_q[MD-1];
        fin_sat = md_sat_q[MD-1];
        fin_p   = md_p_q[MD-1];
      end
    end else begin : g_nomid
      always_comb begin
        fin_v   = s1_v_q;
        fin_rnd = s1_rnd_q;
        fin_sat = s1_sat_q;
        fin_p   = prod_c;
      end
    end
  endgenerate

  always_comb begin
    out_v_d   = out_v_q;
    out_res_d = out_res_q;
    out_ovf_d = out_ovf_q;
    if (adv) begin
      out_v_d = fin_v;
      for (int l = 0; l < LANES; l++)
        {out_ovf_d[l], out_res_d[l*W +: W]} = round_sat(fin_p[l*PW +: PW], fin_rnd, fin_sat);
    end
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr)
      ovf_cnt_d = '0;
    else if (out_v_q && out_rdy && (|out_ovf_q) && (ovf_cnt_q != 16'hFFFF))
      ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_rnd_q  <= 1'b0;
      s1_sat_q  <= 1'b0;
      md_v_q    <= '0;
      md_rnd_q  <= '0;
      md_sat_q  <= '0;
      for (int k = 0; k < MD; k++) md_p_q[k] <= '0;
      out_v_q   <= 1'b0;
      out_res_q <= '0;
      out_ovf_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_rnd_q  <= s1_rnd_d;
      s1_sat_q  <= s1_sat_d;
      md_v_q    <= md_v_d;
      md_rnd_q  <= md_rnd_d;
      md_sat_q  <= md_sat_d;
      md_p_q    <= md_p_d;
      out_v_q   <= out_v_d;
      out_res_q <= out_res_d;
      out_ovf_q <= out_ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_paramult_vec_pipe.sv
module tb_paramult_vec_pipe;
  localparam int LANES = 16;
  localparam int W     = 16;
  localparam int FRAC  = 8;
  localparam int LAT   = 3;
  localparam longint MAXV = 2**(W-1) - 1;
  localparam longint MINV = -(2**(W-1));

  logic               clk = 1'b0;
  logic               rst;
  logic               in_v, in_rdy, rnd_en, sat_en, out_v, out_rdy, ovf_clr, busy;
  logic [LANES*W-1:0] in_a, in_b, out_res;
  logic [LANES-1:0]   out_ovf;
  logic [15:0]        ovf_cnt;

  paramult_vec_pipe #(.LANES(LANES), .W(W), .FRAC(FRAC), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b),
    .rnd_en(rnd_en), .sat_en(sat_en), .out_v(out_v), .out_rdy(out_rdy),
    .out_res(out_res), .out_ovf(out_ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr),
    .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*W-1:0] res;
    logic [LANES-1:0]   ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         rnd, sat;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  exp_t q[$];
  int   exp_cnt = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   n_out = 0;

  task automatic chk(input string name, input logic [LANES*W-1:0] act,
                     input logic [LANES*W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic per lane.
  function automatic exp_t model(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b,
                                 input logic rnd, input logic sat);
    exp_t   e;
    longint p, s;
    logic [63:0] sv;
    for (int l = 0; l < LANES; l++) begin
      p = longint'($signed(a[l*W +: W])) * longint'($signed(b[l*W +: W]));
      if (rnd && FRAC > 0) p = p + (longint'(1) << (FRAC - 1));
      s = p >>> FRAC;
      e.ovf[l] = (s > MAXV) || (s < MINV);
      sv = s;
      if (sat && e.ovf[l]) e.res[l*W +: W] = (s < 0) ? W'(MINV) : W'(MAXV);
      else                 e.res[l*W +: W] = sv[W-1:0];
    end
    return e;
  endfunction

  // Scoreboard: sampled on the falling edge, ahead of the edge that transfers.
  always @(negedge clk) begin
    exp_t e;
    logic ovf_any;
    if (rst) begin
      chk("ovf_cnt", ovf_cnt, exp_cnt);
      chk("busy", busy, q.size() != 0);
      chk("in_rdy", in_rdy, !out_v || out_rdy);
      ovf_any = 1'b0;
      if (out_v && out_rdy) begin
        n_out++;
        if (q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_out: got out_v=1 with nothing in flight, expected none");
        end else begin
          e = q.pop_front();
          chk("out_res", out_res, e.res);
          chk("out_ovf", out_ovf, e.ovf);
          ovf_any = |e.ovf;
        end
      end
      if (ovf_clr) exp_cnt = 0;
      else if (ovf_any && exp_cnt < 65535) exp_cnt++;
      if (in_v && in_rdy) q.push_back(model(in_a, in_b, rnd_en, sat_en));
    end
  end

  task automatic rand_vec();
    for (int l = 0; l < LANES; l++) begin
      in_a[l*W +: W] = W'($urandom);
      in_b[l*W +: W] = W'($urandom);
    end
    rnd_en = 1'($urandom_range(0, 1));
    sat_en = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || out_v) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk(name, q.size(), 0);
  endtask

  vec_t tbl[10];
  logic [LANES*W-1:0] hold;
  int n, n0;
  logic pend;

  initial begin
    tbl[0] = '{16'h0100, 16'h0100, 1'b0, 1'b1, 16'h0100, 1'b0};
    tbl[1] = '{16'h0001, 16'h0080, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[2] = '{16'h0001, 16'h0080, 1'b1, 1'b1, 16'h0001, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0080, 1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    tbl[5] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFF00, 1'b1};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    tbl[7] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b1};
    tbl[8] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    tbl[9] = '{16'h0200, 16'hFF00, 1'b0, 1'b0, 16'hFE00, 1'b0};

    rst = 1'b0; in_v = 1'b0; out_rdy = 1'b1; ovf_clr = 1'b0;
    rnd_en = 1'b0; sat_en = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_v", out_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_rdy", in_rdy, 1);

    // Directed arithmetic vectors, one in flight at a time.
    for (int i = 0; i < 10; i++) begin
      in_a = {LANES{tbl[i].a}}; in_b = {LANES{tbl[i].b}};
      rnd_en = tbl[i].rnd; sat_en = tbl[i].sat; in_v = 1'b1;
      @(posedge clk); #1;
      in_v = 1'b0;
      n = 1;
      while (!out_v && n < 20) begin @(posedge clk); #1; n++; end
      chk($sformatf("latency_%0d", i), n, LAT);
      chk($sformatf("tbl_res_%0d", i), out_res, {LANES{tbl[i].res}});
      chk($sformatf("tbl_ovf_%0d", i), out_ovf, {LANES{tbl[i].ovf}});
      @(posedge clk); #1;
    end
    chk("ovf_cnt_after_table", ovf_cnt, 4);

    // Clear wins over a same-cycle overflow transfer.
    in_a = {LANES{16'h7FFF}}; in_b = {LANES{16'h7FFF}}; rnd_en = 1'b0; sat_en = 1'b1;
    ovf_clr = 1'b1; in_v = 1'b1;
    @(posedge clk); #1;
    in_v = 1'b0;
    n = 1;
    while (!out_v && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr_priority", ovf_cnt, 0);

    // Stall with a held input: the held vector transfers on release.
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      rand_vec(); in_v = 1'b1;
      @(posedge clk); #1;
    end
    rand_vec(); out_rdy = 1'b0;
    #1;
    hold = out_res;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_rdy", in_rdy, 0);
      chk("stall_out_v", out_v, 1);
      chk("stall_out_res", out_res, hold);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    in_v = 1'b0;
    drain("stall_drain");
    chk("stall_count", n_out - n0, 4);

    // Continuous stream: one result per cycle once the pipe is full.
    n0 = n_out;
    for (int i = 0; i < 64; i++) begin
      rand_vec(); in_v = 1'b1;
      @(posedge clk); #1;
      if (i + 1 >= LAT) chk($sformatf("stream_out_v_%0d", i), out_v, 1);
    end
    in_v = 1'b0;
    drain("stream_drain");
    chk("stream_count", n_out - n0, 64);

    // Random valid and random backpressure; the source holds data while stalled.
    pend = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (!pend) begin in_v = 1'($urandom_range(0, 1)); rand_vec(); end
      out_rdy = ($urandom_range(0, 3) != 0);
      #2;
      pend = in_v && !in_rdy;
      @(posedge clk); #1;
    end
    in_v = 1'b0; out_rdy = 1'b1;
    drain("random_drain");

    // Reset with vectors in flight.
    for (int i = 0; i < LAT; i++) begin
      rand_vec(); in_v = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; in_v = 1'b0;
    q.delete(); exp_cnt = 0;
    #1;
    chk("midrst_out_v", out_v, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf_cnt", ovf_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("postrst_out_v", out_v, 0);
    end
    chk("postrst_count", n_out - n0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
